// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Pipeline boundary register between stages, e.g. EX/MEM and MEM/WB.
// It carries a payload bus, a control bus and a destination-register
// index, and uses valid/ready flow control.
//
// With SKID=1 the stage holds two entries (main + skid). in_ready is then
// a plain flop output, so there is no combinational path from out_ready
// to in_ready, and throughput stays at one entry per cycle.
// With SKID=0 the stage holds one entry, and in_ready depends
// combinationally on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low; clears all storage
//   flush      synchronous kill of every held entry; also discards the
//              input offered in the same cycle
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream payload         [DATA_W]
//   in_ctrl    upstream control         [CTRL_W]
//   in_dest    upstream destination idx [DEST_W]
//   out_valid  downstream entry valid
//   out_ready  downstream accepts the entry
//   out_data   held payload (may keep stale bits after a flush)
//   out_ctrl   held control, forced to 0 while out_valid=0
//   out_dest   held destination, forced to 0 while out_valid=0
//   occupancy  number of held entries, registered (0..2)
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 4,
    parameter int DEST_W = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occupancy
);

    // Main entry: this is what the outputs show.
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DEST_W-1:0] main_dest;

    // Skid entry: catches an entry accepted while main is stalled.
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DEST_W-1:0] skid_dest;

    logic [1:0]        occ_q;

    // Next-state values
    logic              main_valid_n;
    logic [DATA_W-1:0] main_data_n;
    logic [CTRL_W-1:0] main_ctrl_n;
    logic [DEST_W-1:0] main_dest_n;
    logic              skid_valid_n;
    logic [DATA_W-1:0] skid_data_n;
    logic [CTRL_W-1:0] skid_ctrl_n;
    logic [DEST_W-1:0] skid_dest_n;
    logic [1:0]        occ_n;

    logic in_xfer;
    logic out_xfer;

    // With the skid buffer, readiness depends only on stored state. Without
    // it, a full stage may accept a new entry in the same cycle that the
    // downstream stage consumes the current one.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = !skid_valid;
        end else begin : g_plain_ready
            assign in_ready = !main_valid | out_ready;
        end
    endgenerate

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    // Next-state selection. The skid entry is only ever filled while main is
    // full, so an empty main always implies an empty skid. That is why the
    // "main empty" branch never has to look at the skid entry.
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_ctrl_n  = main_ctrl;
        main_dest_n  = main_dest;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_ctrl_n  = skid_ctrl;
        skid_dest_n  = skid_dest;

        if (flush) begin
            // The payload is left stale on purpose; gating hides ctrl/dest.
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid) begin
            if (in_xfer) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
                main_ctrl_n  = in_ctrl;
                main_dest_n  = in_dest;
            end
        end else if (out_xfer) begin
            if (skid_valid) begin
                // Oldest waiting entry moves up; in_ready was low, so no input.
                main_data_n  = skid_data;
                main_ctrl_n  = skid_ctrl;
                main_dest_n  = skid_dest;
                skid_valid_n = 1'b0;
            end else if (in_xfer) begin
                main_data_n  = in_data;
                main_ctrl_n  = in_ctrl;
                main_dest_n  = in_dest;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (in_xfer && (SKID != 0)) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
            skid_ctrl_n  = in_ctrl;
            skid_dest_n  = in_dest;
        end

        occ_n = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end

    // State registers. Reset clears everything, including the payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            main_dest  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            skid_dest  <= '0;
            occ_q      <= 2'd0;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            main_ctrl  <= main_ctrl_n;
            main_dest  <= main_dest_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_ctrl  <= skid_ctrl_n;
            skid_dest  <= skid_dest_n;
            occ_q      <= occ_n;
        end
    end

    // Bubble gating: an invalid slot must never assert regwen/MemRW.
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
    assign out_dest  = main_dest & {DEST_W{main_valid}};
    assign occupancy = occ_q;

endmodule
